// File: rtl/rf_param.sv
// Parametrised register file: two registered read ports, one write port, optional
// write-to-read bypass, optional hardwired-zero R0 and a one-register-per-cycle clear sweep.
module rf_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_rega,
    input  logic [ADDR_W-1:0] read_regb,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rf_we,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [DATA_W-1:0] rsa,
    output logic [DATA_W-1:0] rsb
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_next_ptr;
    logic                r_clr_busy;
    logic                w_next_busy;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rsa;
    logic [DATA_W-1:0]   r_rsb;
    logic [DATA_W-1:0]   w_val_a;
    logic [DATA_W-1:0]   w_val_b;
    logic                w_wr_ok;
    logic                w_zero_wr;

    // Write acceptance: only while idle, and never into a hardwired-zero R0
    always_comb begin
        w_zero_wr = (ZERO_REG != 0) && (write_reg == {ADDR_W{1'b0}});
        w_wr_ok   = (r_state == ST_IDLE) && rf_we && !w_zero_wr;
    end

    // Value a read port captures at this edge; the sweep forces reads to zero
    function automatic logic [DATA_W-1:0] f_read_val(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (r_state == ST_SWEEP) begin
            val = {DATA_W{1'b0}};
        end else if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
            val = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && w_wr_ok && (write_reg == addr)) begin
            val = write_data;
        end else begin
            val = r_mem[addr];
        end
        return val;
    endfunction

    // Read-port operand selection
    always_comb begin
        w_val_a = f_read_val(read_rega);
        w_val_b = f_read_val(read_regb);
    end

    // Clear-engine next state: start from IDLE on request, exit after the last register
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_busy  = r_clr_busy;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_next_state = ST_SWEEP;
                    w_next_ptr   = {ADDR_W{1'b0}};
                    w_next_busy  = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                w_next_ptr = r_ptr + ADDR_W'(1);
                if (r_ptr == {ADDR_W{1'b1}}) begin
                    w_next_state = ST_IDLE;
                    w_next_busy  = 1'b0;
                end else begin
                    w_next_state = ST_SWEEP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_ptr   = {ADDR_W{1'b0}};
                w_next_busy  = 1'b0;
            end
        endcase
    end

    // Clear-engine state, pointer and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= {ADDR_W{1'b0}};
            r_clr_busy <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ptr      <= w_next_ptr;
            r_clr_busy <= w_next_busy;
        end
    end

    // Register array: sweep clear takes priority over (and blocks) normal writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (r_state == ST_SWEEP) begin
            r_mem[r_ptr] <= {DATA_W{1'b0}};
        end else if (w_wr_ok) begin
            r_mem[write_reg] <= write_data;
        end else begin
            r_mem[0] <= r_mem[0];
        end
    end

    // Registered read ports with stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsa <= {DATA_W{1'b0}};
            r_rsb <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            r_rsa <= w_val_a;
            r_rsb <= w_val_b;
        end else begin
            r_rsa <= r_rsa;
            r_rsb <= r_rsb;
        end
    end

    assign rsa      = r_rsa;
    assign rsb      = r_rsb;
    assign clr_busy = r_clr_busy;

endmodule

// File: tb/tb_rf_param.sv
// Directed self-checking bench for rf_param: a default instance (ZERO_REG=1, BYPASS=1)
// and an alternate instance (ZERO_REG=0, BYPASS=0) driven by the same stimulus.
module tb_rf_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  read_rega;
    logic [3:0]  read_regb;
    logic        rd_en;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic        rf_we;
    logic        clr_req;
    logic        clr_busy;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic        alt_clr_busy;
    logic [31:0] alt_rsa;
    logic [31:0] alt_rsb;

    int n_checks = 0;
    int n_fail   = 0;

    rf_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .read_rega(read_rega), .read_regb(read_regb), .rd_en(rd_en),
        .write_reg(write_reg), .write_data(write_data), .rf_we(rf_we), .clr_req(clr_req),
        .clr_busy(clr_busy), .rsa(rsa), .rsb(rsb)
    );

    rf_param #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst(rst), .read_rega(read_rega), .read_regb(read_regb), .rd_en(rd_en),
        .write_reg(write_reg), .write_data(write_data), .rf_we(rf_we), .clr_req(clr_req),
        .clr_busy(alt_clr_busy), .rsa(alt_rsa), .rsb(alt_rsb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        rf_we = 1'b1; write_reg = a; write_data = d; rd_en = 1'b0;
        tick();
        rf_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        read_rega = a; read_regb = b; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    int busy_cycles;
    int guard;

    initial begin
        rst = 1'b1; read_rega = 4'd0; read_regb = 4'd0; rd_en = 1'b0;
        write_reg = 4'd0; write_data = 32'd0; rf_we = 1'b0; clr_req = 1'b0;
        tick(); tick();
        check("reset_rsa", rsa, 32'd0);
        check("reset_busy", {31'd0, clr_busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Reset asserted mid-cycle clears outputs without a clock edge
        wr(4'd2, 32'h0000_0055);
        rd(4'd2, 4'd2);
        check("pre_reset_read", rsa, 32'h0000_0055);
        rst = 1'b1;
        #2;
        check("async_reset_rsa", rsa, 32'd0);
        check("async_reset_rsb", rsb, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            rd(i[3:0], 4'(15 - i));
            check("post_reset_regs", rsa | rsb | alt_rsa | alt_rsb, 32'd0);
        end

        // Basic write then dual read of the same register
        wr(4'd5, 32'hDEAD_BEEF);
        rd(4'd5, 4'd5);
        check("r5_rsa", rsa, 32'hDEAD_BEEF);
        check("r5_rsb", rsb, 32'hDEAD_BEEF);

        // Hardwired zero R0 versus ordinary R0
        wr(4'd0, 32'h0000_1234);
        rd(4'd0, 4'd5);
        check("zero_reg_rsa", rsa, 32'd0);
        check("plain_r0_rsa", alt_rsa, 32'h0000_1234);

        // Bypass versus old-value read on a same-edge write
        wr(4'd3, 32'h0000_0011);
        rf_we = 1'b1; write_reg = 4'd3; write_data = 32'hA5A5_A5A5;
        read_rega = 4'd3; read_regb = 4'd5; rd_en = 1'b1;
        tick();
        rf_we = 1'b0;
        check("bypass_rsa", rsa, 32'hA5A5_A5A5);
        check("nobypass_rsa", alt_rsa, 32'h0000_0011);
        tick();
        check("nobypass_next", alt_rsa, 32'hA5A5_A5A5);
        check("rsb_r5", rsb, 32'hDEAD_BEEF);

        // Stall: rd_en low while addresses and contents change
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b0; rf_we = 1'b1; write_reg = 4'd3; write_data = 32'h1000 + 32'(i);
            read_rega = 4'(i + 6); read_regb = 4'd3;
            tick();
            check("hold_rsa", rsa, 32'hA5A5_A5A5);
            check("hold_rsb", rsb, 32'hDEAD_BEEF);
        end
        rf_we = 1'b0;

        // Fill, sweep with a lost write and a restart attempt mid-sweep
        for (int i = 1; i < 16; i++) begin
            wr(i[3:0], 32'h0000_0100 + 32'(i));
        end
        rd(4'd9, 4'd15);
        check("fill_r9", rsa, 32'h0000_0109);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (clr_busy && guard < 40) begin
            busy_cycles++;
            guard++;
            rf_we   = (busy_cycles == 4);
            rd_en   = (busy_cycles == 4);
            clr_req = (busy_cycles == 6);
            write_reg = 4'd7; write_data = 32'h0000_0777; read_rega = 4'd7; read_regb = 4'd7;
            tick();
            if (busy_cycles == 4) begin
                check("sweep_read_zero", rsa | rsb, 32'd0);
            end
        end
        rf_we = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        check("busy_cycles", 32'(busy_cycles), 32'd16);
        tick();
        check("no_restart", {31'd0, clr_busy}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd(i[3:0], 4'(15 - i));
            check("post_sweep_regs", rsa | rsb | alt_rsa | alt_rsb, 32'd0);
        end

        // Reset in the middle of a sweep (ptr == 8)
        wr(4'd9, 32'h0000_0099);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (8) tick();
        check("busy_before_rst", {31'd0, clr_busy}, 32'd1);
        rst = 1'b1;
        #2;
        check("busy_async_clear", {31'd0, clr_busy}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        rd(4'd9, 4'd9);
        check("r9_after_rst", rsa, 32'd0);
        wr(4'd4, 32'h0000_0044);
        rd(4'd4, 4'd9);
        check("idle_after_rst", rsa, 32'h0000_0044);
        check("alt_idle_after_rst", alt_rsa, 32'h0000_0044);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
